// File: rtl/multicycle_controller.sv
// Multi-cycle X-RISC control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath strobes and the ALU operation code, stalls on mem_ready.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_control,
    output logic [1:0] imm_src,
    output logic       illegal
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BRANCH, JAL, HALT
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010,
                           ALU_OR   = 4'b0011, ALU_XOR = 4'b0100, ALU_SLT = 4'b0101,
                           ALU_SLTU = 4'b0110, ALU_SLL = 4'b0111, ALU_SRL = 4'b1000,
                           ALU_SRA  = 4'b1001;

    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R   = 7'b0110011,
                           OP_I  = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;

    state_t state, next;
    logic   mreq, mwr, irw, pcw, rw;

    // Shared R/I funct3 decode; I-type never subtracts on funct3=000.
    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic f7, input logic is_r);
        case (f3)
            3'b000:  alu_decode = (is_r && f7) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_decode = ALU_SLL;
            3'b010:  alu_decode = ALU_SLT;
            3'b011:  alu_decode = ALU_SLTU;
            3'b100:  alu_decode = ALU_XOR;
            3'b101:  alu_decode = f7 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_decode = ALU_OR;
            default: alu_decode = ALU_AND;
        endcase
    endfunction

    // State register; reset aborts any in-flight memory request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= next;
    end

    // Next-state and Moore outputs (FETCH/BRANCH strobes qualified by inputs).
    always_comb begin
        next        = state;
        mreq        = 1'b0;
        mwr         = 1'b0;
        irw         = 1'b0;
        pcw         = 1'b0;
        rw          = 1'b0;
        adr_src     = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        case (state)
            FETCH: begin
                mreq       = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                irw        = mem_ready;
                pcw        = mem_ready;
                if (mem_ready) next = DECODE;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LW, OP_SW: next = MEMADR;
                    OP_R:         next = EXECR;
                    OP_I:         next = EXECI;
                    OP_BR:        next = (funct3[2:1] == 2'b00) ? BRANCH : HALT;
                    OP_JAL:       next = JAL;
                    default:      next = HALT;
                endcase
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                next      = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mreq    = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) next = MEMWB;
            end
            MEMWB: begin
                result_src = 2'b01;
                rw         = 1'b1;
                next       = FETCH;
            end
            MEMWRITE: begin
                mreq    = 1'b1;
                mwr     = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) next = FETCH;
            end
            EXECR: begin
                alu_src_a   = 2'b10;
                alu_control = alu_decode(funct3, funct7b5, 1'b1);
                next        = ALUWB;
            end
            EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = alu_decode(funct3, funct7b5, 1'b0);
                next        = ALUWB;
            end
            ALUWB: begin
                rw   = 1'b1;
                next = FETCH;
            end
            BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = ALU_SUB;
                pcw         = zero ^ funct3[0];
                next        = FETCH;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pcw       = 1'b1;
                next      = ALUWB;
            end
            HALT: begin
                illegal = 1'b1;
            end
            default: next = FETCH;
        endcase
    end

    // Strobes are forced low for the whole reset pulse, not just after the edge.
    assign mem_req   = mreq & rst_n;
    assign mem_write = mwr  & rst_n;
    assign ir_write  = irw  & rst_n;
    assign pc_write  = pcw  & rst_n;
    assign reg_write = rw   & rst_n;

    // Immediate format follows the opcode directly.
    always_comb begin
        case (op)
            OP_SW:   imm_src = 2'b01;
            OP_BR:   imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM for the multi-cycle X-RISC core. It sequences fetch, decode, execute, memory and writeback for a small RV32I subset. It drives the datapath strobes and the 4-bit ALU operation code into the ALU, and stalls on a memory ready handshake. It is the producer side of the ALU control interface: every `alu_control` value the ALU accepts originates here.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `op`  in  7  opcode from instruction register
- `funct3`  in  3  instruction bits 14:12
- `funct7b5`  in  1  instruction bit 30
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory completes current request this cycle
- `mem_req`  out  1  memory request valid
- `mem_write`  out  1  request is a store
- `adr_src`  out  1  0 = PC, 1 = ALUOut as memory address
- `ir_write`  out  1  load instruction register
- `pc_write`  out  1  load PC from result bus
- `reg_write`  out  1  register-file write enable
- `result_src`  out  2  00 ALUOut, 01 memory data, 10 ALUResult
- `alu_src_a`  out  2  00 PC, 01 OldPC, 10 rs1 register
- `alu_src_b`  out  2  00 rs2 register, 01 immediate, 10 constant 4
- `alu_control`  out  4  ALU operation code
- `imm_src`  out  2  00 I, 01 S, 10 B, 11 J
- `illegal`  out  1  sticky: unsupported instruction decoded

## Operation
- ALU codes:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor
  - 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra
- States (4-bit): FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, HALT.
- Outputs are a Moore decode of state, except that `pc_write`/`ir_write` in FETCH and `pc_write` in BRANCH are qualified by inputs.
- Any signal not listed for a state is 0. `alu_control` defaults to 0000.
- FETCH:
  - Outputs: `mem_req`=1, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, add, `result_src`=10.
  - `ir_write`=`pc_write`=`mem_ready`.
  - Go to DECODE when `mem_ready`=1, otherwise hold.
- DECODE:
  - Outputs: `alu_src_a`=01, `alu_src_b`=01, add (branch/jump target into ALUOut).
  - Next state by `op`:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 with `funct3` 000/001 → BRANCH
    - 1101111 → JAL
    - anything else → HALT
- MEMADR: `alu_src_a`=10, `alu_src_b`=01, add. Next state is MEMREAD if `op`[5]=0, else MEMWRITE.
- MEMREAD: `mem_req`=1, `adr_src`=1. Hold until `mem_ready`, then MEMWB.
- MEMWB: `result_src`=01, `reg_write`=1, then FETCH.
- MEMWRITE: `mem_req`=1, `mem_write`=1, `adr_src`=1. Hold until `mem_ready`, then FETCH.
- EXECR: `alu_src_a`=10, `alu_src_b`=00, R-decode, then ALUWB.
- EXECI: `alu_src_a`=10, `alu_src_b`=01, I-decode, then ALUWB.
- ALUWB: `result_src`=00, `reg_write`=1, then FETCH.
- BRANCH: `alu_src_a`=10, `alu_src_b`=00, sub, `result_src`=00. `pc_write`=`zero` XOR `funct3`[0]. Then FETCH.
- JAL: `alu_src_a`=01, `alu_src_b`=10, add, `result_src`=00, `pc_write`=1, then ALUWB (writes OldPC+4).
- HALT: all strobes 0, `illegal`=1. Stays in HALT until reset.
- R-decode by `funct3`:
  - 000: sub if `funct7b5`, else add
  - 001 sll, 010 slt, 011 sltu, 100 xor
  - 101: sra if `funct7b5`, else srl
  - 110 or, 111 and
- I-decode: same as R-decode, except 000 is always add.
- `imm_src`, combinational from `op`:
  - 0100011 → 01
  - 1100011 → 10
  - 1101111 → 11
  - else 00

## Timing
- Reset:
  - State = FETCH; `illegal`=0.
  - While `rst_n`=0, `mem_req`, `mem_write`, `ir_write`, `pc_write` and `reg_write` are forced to 0.
  - Deassertion takes effect at the next rising edge.
- A reset asserted in any state, including a stalled MEMREAD/MEMWRITE, aborts immediately. No write strobe is emitted afterwards.
- Cycles per instruction with `mem_ready` held at 1: lw 5, sw 4, R 4, I 4, branch 3, jal 4. Each stall cycle adds 1.
- `mem_req` stays high and the address source stays stable for every cycle of a stall.
- `mem_write` is high only in MEMWRITE.
- `op`, `funct3` and `funct7b5` must be stable from DECODE until the return to FETCH.

## Test plan
- Reset mid-stall: in MEMWRITE with `mem_ready`=0, pulse `rst_n` low → all strobes 0 immediately; state is FETCH after release.
- Fetch stall: hold `mem_ready`=0 for 3 cycles in FETCH → `mem_req`=1 throughout, `ir_write`/`pc_write`=0. On the ready cycle both =1, then DECODE.
- R-type sweep: with `op`=0110011, drive every `funct3`×`funct7b5` combination → in EXECR, `alu_control` = {0000/0001, 0111, 0101, 0110, 0100, 1000/1001, 0011, 0010}. ALUWB follows with `reg_write`=1.
- lw with `mem_ready` always 1 → state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB (5 cycles). MEMWB has `result_src`=01; the next cycle is FETCH.
- Branch: beq with `zero`=1 → `pc_write`=1 in BRANCH; bne with `zero`=1 → `pc_write`=0. Both use `alu_control`=0001.
- Illegal: `op`=1111111 → HALT, `illegal`=1 held for 20 cycles with no strobes; cleared only by `rst_n`.
